// File: rtl/mux_rr_sched.sv
// mux_rr_sched: round-robin scheduler that shares one W-bit output mux
// between N requesters. One requester is granted at a time; a grant is cut
// after MAX_HOLD cycles if someone else is waiting, and every grant is
// followed by a single gnt=0 cycle (break-before-make). The granted
// requester's data is registered onto out_data one cycle behind gnt.
//
// Handshake: req[i] is a level; the requester keeps it high while it wants
// service. gnt[i] high means requester i owns the mux this cycle; the data
// it drives appears on out_data (with out_valid=1) one cycle later. There
// is no backpressure: dropping req[i] releases the grant.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-high reset
//   ena       global enable; low freezes every register
//   req       [N-1:0]   per-requester request level
//   data_in   [N*W-1:0] requester data, slice i = data_in[i*W +: W]
//   gnt       [N-1:0]   registered one-hot grant
//   sel       index of current/last granted requester (registered)
//   out_data  [W-1:0]   registered mux output, 0 when not valid
//   out_valid out_data carries granted data
//   busy      high in GRANT and GAP (also serves as FSM activity probe)
module mux_rr_sched #(
  parameter int N        = 4,
  parameter int W        = 2,
  parameter int MAX_HOLD = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic [N-1:0]         req,
  input  logic [N*W-1:0]       data_in,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] sel,
  output logic [W-1:0]         out_data,
  output logic                 out_valid,
  output logic                 busy
);

  localparam int SW = $clog2(N);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] ptr_q, ptr_d;
  logic [3:0]    hold_q, hold_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [W-1:0]  out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;

  // Winner search: first requester at or after ptr, wrapping modulo N.
  logic          win_found;
  logic [SW-1:0] win_idx;
  int            scan_idx;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = 0;
    for (int k = 0; k < N; k++) begin
      scan_idx = int'(ptr_q) + k;
      if (scan_idx >= N) scan_idx = scan_idx - N;
      if (!win_found && req[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = SW'(scan_idx);
      end
    end
  end

  logic [W-1:0] mux_data;
  logic         others_req;

  assign mux_data   = data_in[sel_q*W +: W];
  // gnt_q is one-hot on sel_q while in GRANT, so masking it leaves the others.
  assign others_req = |(req & ~gnt_q);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    hold_d      = hold_q;
    gnt_d       = gnt_q;
    sel_d       = sel_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;

    if (ena) begin
      // Output stage follows the previous cycle's registered grant.
      out_valid_d = |gnt_q;
      out_data_d  = (|gnt_q) ? mux_data : '0;

      case (state_q)
        ST_GRANT: begin
          if (!req[sel_q] || ((hold_q == 4'(MAX_HOLD)) && others_req)) begin
            // ptr moves on entering GAP so the GAP-cycle search already
            // starts after the requester that just finished.
            state_d = ST_GAP;
            gnt_d   = '0;
            ptr_d   = (sel_q == SW'(N - 1)) ? '0 : sel_q + 1'b1;
          end else if (hold_q != 4'(MAX_HOLD)) begin
            hold_d = hold_q + 4'd1;
          end
        end
        default: begin // ST_IDLE and ST_GAP both grant the winner if any
          gnt_d = '0;
          if (win_found) begin
            state_d        = ST_GRANT;
            gnt_d[win_idx] = 1'b1;
            sel_d          = win_idx;
            hold_d         = 4'd1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      hold_q      <= '0;
      gnt_q       <= '0;
      sel_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      hold_q      <= hold_d;
      gnt_q       <= gnt_d;
      sel_q       <= sel_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign gnt       = gnt_q;
  assign sel       = sel_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: doc/mux_rr_sched.md
# mux_rr_sched

Round-robin scheduler that shares one W-bit output mux between N requesters. It grants one requester at a time, bounds each grant to MAX_HOLD cycles when others are waiting, and inserts a one-cycle break-before-make gap between grants. It registers the selected requester's data onto a single output bus. It sits between the `ui_in`-driven requesters and the `uo_out` pin mux in the tt_um top level, and replaces the direct combinational select.

## Interface

Parameters:
- N, 4, number of requesters (2..8)
- W, 2, data width per requester
- MAX_HOLD, 4, maximum grant length in cycles while other requests are pending (1..15)

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  reset, asynchronous, active-high
- ena  input  1  global enable; when low, every register holds its value
- req  input  N  request per requester; level-sensitive, held high while service is wanted
- data_in  input  N*W  requester data; slice i is data_in[i*W +: W]
- gnt  output  N  one-hot grant, registered; all zero when no grant is active
- sel  output  clog2(N)  index of the current or last granted requester, registered
- out_data  output  W  registered mux output
- out_valid  output  1  out_data carries the data of a granted requester
- busy  output  1  high in GRANT and GAP states

## Operation

- Three states: IDLE, GRANT, GAP. Internal registers:
  - ptr: round-robin start index, reset to 0
  - hold_cnt: 4 bits, saturating at MAX_HOLD
- Winner: the first requester with req=1, searching ptr, ptr+1, …, N-1, 0, …, ptr-1 (wraps modulo N).
- IDLE:
  - If any req is high, go to GRANT with gnt[winner]=1, sel=winner, hold_cnt=1.
  - Otherwise stay in IDLE with gnt=0.
- GRANT(i):
  - If req[i]=0, go to GAP (voluntary release).
  - Else if hold_cnt==MAX_HOLD and any other req bit is high, go to GAP (forced rotation).
  - Otherwise stay; hold_cnt increments and saturates at MAX_HOLD. A lone requester keeps the grant indefinitely.
- GAP:
  - gnt=0 for exactly one cycle; ptr becomes (i+1) mod N.
  - Next state is GRANT to the winner, computed with the new ptr from req sampled in the GAP cycle. If no req is high, next state is IDLE.
- sel holds its last value in IDLE and GAP.
- out_data and out_valid:
  - Each edge, out_data is loaded with data_in[sel*W +: W] and out_valid with |gnt, both taken from the previous cycle's registered values.
  - When out_valid=0, out_data is forced to 0.
- ena=0: state, ptr, hold_cnt, gnt, sel, out_data and out_valid all hold. req and data_in are ignored.
- Reset values: state=IDLE, ptr=0, hold_cnt=0, gnt=0, sel=0, out_data=0, out_valid=0, busy=0.

## Timing

- Request to grant: 1 cycle. req rising before edge k gives gnt high after edge k, provided the block is in IDLE.
- Grant to data: out_valid and out_data follow gnt by 1 cycle and drop 1 cycle after gnt drops.
- Release: req[i] low before edge k gives gnt[i]=0 after edge k (GAP). The next grant appears after edge k+1.
- Forced rotation: a grant lasts exactly MAX_HOLD cycles, then 1 gap cycle. With all N requesting, the cycle period is N*(MAX_HOLD+1).
- Simultaneous events:
  - req[i] drops in the same cycle other requests rise: the gap is still taken.
  - A request arriving during GAP is eligible for the grant that follows.
- ptr wraps from N-1 to 0.
- gnt is never multi-hot and never changes directly from one requester to another; a zero cycle always separates grants.
- rst asserted mid-grant: all outputs go to reset values immediately without waiting for clk. The first grant after release of rst starts the search at index 0.

## Test plan

- Reset mid-operation: gnt=0100, then rst pulses between edges → gnt, sel, out_valid and busy read 0 before the next edge. After release with req=1010, the first grant is gnt=0010.
- Single requester: req=0100 for 3 cycles, data_in[5:4]=2'b11 → gnt=0100 for cycles 1–3, out_valid/out_data=11 for cycles 2–4, gnt=0 in cycle 4 (GAP), IDLE in cycle 5, out_data=0 in cycle 5.
- Full contention: req=1111 held, MAX_HOLD=4 → grants 0,1,2,3,0 in sequence, each exactly 4 cycles, with 1 gnt=0 cycle between them; period 20 cycles.
- Lone holder beyond the limit: req=0010 held 10 cycles → gnt=0010 is uninterrupted. req[3] rises in cycle 10 → GAP in cycle 11, gnt=1000 in cycle 12.
- ena freeze: ena=0 for 3 cycles during GRANT with hold_cnt=2 → all outputs are unchanged during the freeze. After ena returns, rotation happens 2 cycles later, not sooner.
- Wrap and priority: last grant is requester 3, req=1001 → the next grant goes to requester 0 (ptr wrapped), not 3.
